// File: rtl/counter_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : counter_chk_pkg
//  Purpose  : Shared types, constants and the golden next-count function for
//             the 4-bit counter checker and its simulation bench.
//  Revision : 1.0 - initial release
// ============================================================================
package counter_chk_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      HALT  = 2'd2
   } chk_state_t;

   // Golden counter rule: load beats enable, enable wraps 15 -> 0, else hold.
   function automatic logic [CNT_W-1:0] next_count(
      input logic [CNT_W-1:0] cur,
      input logic             load,
      input logic             en,
      input logic [CNT_W-1:0] data
   );
      logic [CNT_W-1:0] nxt;
      nxt = cur;
      if (load) begin
         nxt = data;
      end else if (en) begin
         nxt = cur + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      return nxt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/counter_checker_if.sv
`default_nettype none
// ============================================================================
//  Module   : counter_checker_if
//  Purpose  : Bus of the observed 4-bit counter: control/data towards the
//             counter and its count/even outputs.
//  Revision : 1.0 - initial release
// ============================================================================
interface counter_checker_if;
   import counter_chk_pkg::*;

   logic             enable_i;
   logic             load_i;
   logic [CNT_W-1:0] data_i;
   logic [CNT_W-1:0] count_o;
   logic             even_o;

   // Side that drives the counter controls
   modport master (
      output enable_i, load_i, data_i,
      input  count_o, even_o
   );

   // The counter itself
   modport slave (
      input  enable_i, load_i, data_i,
      output count_o, even_o
   );

   // Passive observer: reads everything, drives nothing
   modport monitor (
      input enable_i, load_i, data_i, count_o, even_o
   );
endinterface
`default_nettype wire

// File: rtl/counter_checker_ref_model.sv
`default_nettype none
// ============================================================================
//  Module   : counter_ref_model
//  Purpose  : Shadow copy of the observed counter. Resyncs from the DUT count
//             while idle, free-runs from its own state while checking, and
//             holds otherwise.
//  Revision : 1.0 - initial release
// ============================================================================
module counter_ref_model
   import counter_chk_pkg::*;
(
   input  wire logic             clk_i,
   input  wire logic             rst_n_i,
   input  wire logic             resync_i,
   input  wire logic             advance_i,
   input  wire logic             load_i,
   input  wire logic             enable_i,
   input  wire logic [CNT_W-1:0] data_i,
   input  wire logic [CNT_W-1:0] dut_count_i,
   output logic      [CNT_W-1:0] exp_o
);

   logic [CNT_W-1:0] exp_q;
   logic [CNT_W-1:0] exp_d;

   // Next expected count: follow the DUT when resyncing, else the model itself
   always_comb begin
      exp_d = exp_q;
      if (resync_i) begin
         exp_d = next_count(dut_count_i, load_i, enable_i, data_i);
      end else if (advance_i) begin
         exp_d = next_count(exp_q, load_i, enable_i, data_i);
      end
   end

   // Expected-count register with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         exp_q <= '0;
      end else begin
         exp_q <= exp_d;
      end
   end

   assign exp_o = exp_q;

endmodule
`default_nettype wire

// File: rtl/counter_checker.sv
`default_nettype none
// ============================================================================
//  Module   : counter_checker
//  Purpose  : Passive cycle-by-cycle checker for the 4-bit counter bus.
//             Reports mismatches as a pulse, sticky flag, saturating count
//             and a capture of the first failing expected/observed pair.
//  Revision : 1.0 - initial release
// ============================================================================
module counter_checker
   import counter_chk_pkg::*;
#(
   parameter int ERR_CNT_W   = 8,
   parameter bit STOP_ON_ERR = 1'b0
)(
   input  wire logic                 clk_i,
   input  wire logic                 rst_n_i,
   counter_checker_if.monitor        bus,
   input  wire logic                 chk_en_i,
   input  wire logic                 clr_i,
   output logic                      mismatch_o,
   output logic                      err_o,
   output logic      [ERR_CNT_W-1:0] err_cnt_o,
   output logic      [CNT_W:0]       first_exp_o,
   output logic      [CNT_W:0]       first_got_o,
   output logic      [1:0]           state_o
);

   chk_state_t           state_q, state_d;
   logic                 mismatch_q, mismatch_d;
   logic                 err_q, err_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W:0]       first_exp_q, first_exp_d;
   logic [CNT_W:0]       first_got_q, first_got_d;

   logic [CNT_W-1:0]     exp_cnt;
   logic [CNT_W:0]       exp_word;
   logic [CNT_W:0]       got_word;
   logic                 compare_hit;
   logic                 mis_accept;

   counter_ref_model u_ref (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .resync_i    (state_q == IDLE),
      .advance_i   (state_q == CHECK),
      .load_i      (bus.load_i),
      .enable_i    (bus.enable_i),
      .data_i      (bus.data_i),
      .dut_count_i (bus.count_o),
      .exp_o       (exp_cnt)
   );

   // Compare model against DUT; a clear at the same edge swallows the mismatch
   always_comb begin
      exp_word    = {~exp_cnt[0], exp_cnt};
      got_word    = {bus.even_o, bus.count_o};
      compare_hit = (state_q == CHECK) && (exp_word != got_word);
      mis_accept  = compare_hit && !clr_i;
   end

   // Next-state logic for IDLE / CHECK / HALT
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (chk_en_i) state_d = CHECK;
         end
         CHECK: begin
            if (mis_accept && STOP_ON_ERR) state_d = HALT;
            else if (!chk_en_i)            state_d = IDLE;
         end
         HALT: begin
            if (clr_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Error status: pulse, sticky flag, saturating count, first-failure capture
   always_comb begin
      mismatch_d  = mis_accept;
      err_d       = err_q;
      err_cnt_d   = err_cnt_q;
      first_exp_d = first_exp_q;
      first_got_d = first_got_q;
      if (clr_i) begin
         err_d       = 1'b0;
         err_cnt_d   = '0;
         first_exp_d = '0;
         first_got_d = '0;
      end else if (mis_accept) begin
         if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
         end
         if (!err_q) begin
            first_exp_d = exp_word;
            first_got_d = got_word;
         end
         err_d = 1'b1;
      end
   end

   // State and status registers with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         mismatch_q  <= 1'b0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
         first_exp_q <= '0;
         first_got_q <= '0;
      end else begin
         state_q     <= state_d;
         mismatch_q  <= mismatch_d;
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
         first_exp_q <= first_exp_d;
         first_got_q <= first_got_d;
      end
   end

   assign mismatch_o  = mismatch_q;
   assign err_o       = err_q;
   assign err_cnt_o   = err_cnt_q;
   assign first_exp_o = first_exp_q;
   assign first_got_o = first_got_q;
   assign state_o     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_checker
//  Purpose  : Bench for counter_checker. Three checker instances watch one
//             bus: default, 2-bit saturating count, and stop-on-error.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_counter_checker;
   import counter_chk_pkg::*;

   localparam int F_MIS = 0;
   localparam int F_ERR = 1;
   localparam int F_CNT = 2;
   localparam int F_FE  = 3;
   localparam int F_FG  = 4;
   localparam int F_ST  = 5;
   localparam int I_DF  = 0;
   localparam int I_SAT = 1;
   localparam int I_STP = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic chk_en;
   logic clr;

   counter_checker_if bus ();

   logic       mis [3];
   logic       err [3];
   logic [7:0] cnt [3];
   logic [1:0] cnt_sat;
   logic [4:0] fe  [3];
   logic [4:0] fg  [3];
   logic [1:0] st  [3];

   always #5 clk = ~clk;

   counter_checker #(.ERR_CNT_W(8), .STOP_ON_ERR(1'b0)) u_dflt (
      .clk_i(clk), .rst_n_i(rst_n), .bus(bus), .chk_en_i(chk_en), .clr_i(clr),
      .mismatch_o(mis[0]), .err_o(err[0]), .err_cnt_o(cnt[0]),
      .first_exp_o(fe[0]), .first_got_o(fg[0]), .state_o(st[0]));

   counter_checker #(.ERR_CNT_W(2), .STOP_ON_ERR(1'b0)) u_sat (
      .clk_i(clk), .rst_n_i(rst_n), .bus(bus), .chk_en_i(chk_en), .clr_i(clr),
      .mismatch_o(mis[1]), .err_o(err[1]), .err_cnt_o(cnt_sat),
      .first_exp_o(fe[1]), .first_got_o(fg[1]), .state_o(st[1]));

   counter_checker #(.ERR_CNT_W(8), .STOP_ON_ERR(1'b1)) u_stop (
      .clk_i(clk), .rst_n_i(rst_n), .bus(bus), .chk_en_i(chk_en), .clr_i(clr),
      .mismatch_o(mis[2]), .err_o(err[2]), .err_cnt_o(cnt[2]),
      .first_exp_o(fe[2]), .first_got_o(fg[2]), .state_o(st[2]));

   assign cnt[1] = {6'b0, cnt_sat};

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Behavioural good counter plus fault override
   logic [3:0] good;
   logic       fault;
   logic [3:0] fcnt;
   logic       feven;

   function automatic logic [31:0] obs(input int sel);
      int inst;
      int f;
      inst = sel / 8;
      f    = sel % 8;
      case (f)
         F_MIS:   return {31'b0, mis[inst]};
         F_ERR:   return {31'b0, err[inst]};
         F_CNT:   return {24'b0, cnt[inst]};
         F_FE:    return {27'b0, fe[inst]};
         F_FG:    return {27'b0, fg[inst]};
         default: return {30'b0, st[inst]};
      endcase
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input int inst, input int f, input logic [31:0] v);
      exp_t e;
      e.tag = $sformatf("%s.i%0d.f%0d", tag, inst, f);
      e.sel = inst * 8 + f;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic push_all(input string tag, input int inst, input logic m, input logic e,
                           input logic [7:0] c, input logic [4:0] x, input logic [4:0] g,
                           input logic [1:0] s);
      push(tag, inst, F_MIS, {31'b0, m});
      push(tag, inst, F_ERR, {31'b0, e});
      push(tag, inst, F_CNT, {24'b0, c});
      push(tag, inst, F_FE,  {27'b0, x});
      push(tag, inst, F_FG,  {27'b0, g});
      push(tag, inst, F_ST,  {30'b0, s});
   endtask

   task automatic apply_dut();
      if (fault) begin
         bus.count_o = fcnt;
         bus.even_o  = feven;
      end else begin
         bus.count_o = good;
         bus.even_o  = ~good[0];
      end
   endtask

   // One clock: DUT samples, good counter advances, then pending expectations are checked
   task automatic step();
      exp_t e;
      @(posedge clk);
      #1;
      if (!rst_n) good = 4'd0;
      else        good = next_count(good, bus.load_i, bus.enable_i, bus.data_i);
      apply_dut();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_val(e.tag, obs(e.sel), e.val);
      end
   endtask

   task automatic restart(input string tag);
      rst_n = 1'b0; chk_en = 1'b0; clr = 1'b0;
      bus.enable_i = 1'b0; bus.load_i = 1'b0; bus.data_i = 4'd0;
      fault = 1'b0;
      apply_dut();
      for (int i = 0; i < 3; i++) push_all({tag, ".rst"}, i, 1'b0, 1'b0, 8'd0, 5'd0, 5'd0, 2'd0);
      step();
      rst_n = 1'b1; chk_en = 1'b1;
      for (int i = 0; i < 3; i++) push({tag, ".go"}, i, F_ST, 32'd1);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      good = 4'd0; fcnt = 4'd0; feven = 1'b0; fault = 1'b0;

      // 1: correct DUT counting through a wrap
      restart("p1");
      bus.enable_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         push("p1.run", I_DF, F_MIS, 32'd0);
         push("p1.run", I_DF, F_ST, 32'd1);
         step();
      end
      push_all("p1.end", I_DF, 1'b0, 1'b0, 8'd0, 5'd0, 5'd0, 2'd1);
      step();

      // 2: DUT shows 5 where 6 is expected
      restart("p2");
      bus.load_i = 1'b1; bus.data_i = 4'd5;
      push("p2.ld", I_DF, F_MIS, 32'd0);
      step();
      bus.load_i = 1'b0; bus.enable_i = 1'b1;
      fault = 1'b1; fcnt = 4'd5; feven = 1'b0;
      push("p2.pre", I_DF, F_MIS, 32'd0);
      step();
      bus.enable_i = 1'b0; fault = 1'b0;
      push_all("p2.hit", I_DF, 1'b1, 1'b1, 8'd1, 5'b10110, 5'b00101, 2'd1);
      push("p2.hit", I_STP, F_ST, 32'd2);
      push("p2.hit", I_SAT, F_CNT, 32'd1);
      step();
      push_all("p2.after", I_DF, 1'b0, 1'b1, 8'd1, 5'b10110, 5'b00101, 2'd1);
      push("p2.after", I_STP, F_ST, 32'd2);
      step();

      // 3: load beats enable; then a DUT that overshoots the load by one
      restart("p3");
      bus.load_i = 1'b1; bus.enable_i = 1'b1; bus.data_i = 4'd9;
      push("p3.ld", I_DF, F_MIS, 32'd0);
      step();
      bus.load_i = 1'b0; bus.enable_i = 1'b0;
      push("p3.ok", I_DF, F_MIS, 32'd0);
      push("p3.ok", I_DF, F_ERR, 32'd0);
      step();
      bus.load_i = 1'b1; bus.enable_i = 1'b1; bus.data_i = 4'd9;
      fault = 1'b1; fcnt = 4'd10; feven = 1'b1;
      push("p3.ld2", I_DF, F_MIS, 32'd0);
      step();
      bus.load_i = 1'b0; bus.enable_i = 1'b0; fault = 1'b0;
      push_all("p3.hit", I_DF, 1'b1, 1'b1, 8'd1, 5'b01001, 5'b11010, 2'd1);
      step();

      // 4: persistent fault, 2-bit counter saturates
      restart("p4");
      fault = 1'b1; fcnt = 4'd7; feven = 1'b0;
      apply_dut();
      for (int i = 1; i <= 6; i++) begin
         push_all("p4.sat", I_SAT, 1'b1, 1'b1, (i > 3) ? 8'd3 : 8'(i), 5'b10000, 5'b00111, 2'd1);
         push("p4.df", I_DF, F_CNT, 32'(i));
         push_all("p4.stop", I_STP, (i == 1), 1'b1, 8'd1, 5'b10000, 5'b00111, 2'd2);
         step();
      end

      // 5: clear wins over a same-edge mismatch; HALT leaves to IDLE then resumes
      clr = 1'b1;
      push_all("p5.clr", I_DF, 1'b0, 1'b0, 8'd0, 5'd0, 5'd0, 2'd1);
      push_all("p5.clr", I_SAT, 1'b0, 1'b0, 8'd0, 5'd0, 5'd0, 2'd1);
      push_all("p5.clr", I_STP, 1'b0, 1'b0, 8'd0, 5'd0, 5'd0, 2'd0);
      step();
      clr = 1'b0; fault = 1'b0;
      apply_dut();
      push("p5.go", I_STP, F_ST, 32'd1);
      push("p5.go", I_DF, F_MIS, 32'd0);
      step();
      bus.enable_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         push_all("p5.run", I_STP, 1'b0, 1'b0, 8'd0, 5'd0, 5'd0, 2'd1);
         step();
      end

      // 6: reset mid-CHECK with an error pending
      bus.enable_i = 1'b0;
      fault = 1'b1; fcnt = ~good; feven = good[0];
      push("p6.pre", I_DF, F_MIS, 32'd0);
      step();
      fault = 1'b0;
      push("p6.hit", I_DF, F_ERR, 32'd1);
      push("p6.hit", I_DF, F_MIS, 32'd1);
      step();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) push_all("p6.rst", i, 1'b0, 1'b0, 8'd0, 5'd0, 5'd0, 2'd0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
